// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Shares the board's 16-bit asynchronous SRAM between the SLC-3 CPU memory
// port (c_*) and the program-loader/debug port (l_*). Requests are granted
// round-robin, the active-low SRAM strobes are sequenced through a fixed
// SETUP / ACCESS / DONE pattern, and the bidirectional Data bus is driven only
// while a write is in its ACCESS phase.
//
// Parameters
//   WAIT_CYCLES  number of ACCESS cycles per transfer, legal range 1..15
//
// Ports
//   Clk                   system clock, all state changes on the rising edge
//   Reset                 synchronous, active-high
//   c_req/c_we/c_addr/c_wdata   CPU request, direction, word address, write data
//   c_rdata / c_done      CPU read data (held) and one-cycle completion pulse
//   l_*                   loader port, same meaning as the CPU port
//   CE, UB, LB, OE, WE    SRAM strobes, active-low
//   ADDR                  SRAM word address, holds its value between transfers
//   Data                  SRAM data bus (tri-state)
//   busy                  high whenever the sequencer is not idle
//   owner                 port of the current/most recent grant (0 CPU, 1 loader)
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a request; arbitration happens only here
// SETUP  | address and chip enables asserted, OE asserted for reads
// ACCESS | WAIT_CYCLES cycles: read with OE low, or write with WE low
// DONE   | strobes released, bus turnaround, done pulse to granted port
// -----------------------------------------------------------------------------
module sram_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,

    input  logic        c_req,
    input  logic        c_we,
    input  logic [19:0] c_addr,
    input  logic [15:0] c_wdata,
    output logic [15:0] c_rdata,
    output logic        c_done,

    input  logic        l_req,
    input  logic        l_we,
    input  logic [19:0] l_addr,
    input  logic [15:0] l_wdata,
    output logic [15:0] l_rdata,
    output logic        l_done,

    output logic        CE,
    output logic        UB,
    output logic        LB,
    output logic        OE,
    output logic        WE,
    output logic [19:0] ADDR,
    inout  wire  [15:0] Data,

    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // The counter is loaded with WAIT_CYCLES-1 and the last ACCESS cycle is
    // the one where it reads zero.
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state_q,   state_d;
    logic        owner_q,   owner_d;
    logic        we_q,      we_d;
    logic [19:0] addr_q,    addr_d;
    logic [15:0] wdata_q,   wdata_d;
    logic [3:0]  cnt_q,     cnt_d;
    logic [15:0] c_rdata_q, c_rdata_d;
    logic [15:0] l_rdata_q, l_rdata_d;

    logic        grant_c;
    logic        grant_l;
    logic        data_oe;

    // Round-robin: with both ports requesting, the port that did not win
    // last time gets the bus. owner resets to the loader so the CPU wins the
    // very first contested request.
    always_comb begin
        grant_c = 1'b0;
        grant_l = 1'b0;
        if (c_req && l_req) begin
            grant_c = owner_q;
            grant_l = ~owner_q;
        end else begin
            grant_c = c_req;
            grant_l = l_req;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        c_rdata_d = c_rdata_q;
        l_rdata_d = l_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_c) begin
                    owner_d = 1'b0;
                    we_d    = c_we;
                    addr_d  = c_addr;
                    wdata_d = c_wdata;
                    state_d = ST_SETUP;
                end else if (grant_l) begin
                    owner_d = 1'b1;
                    we_d    = l_we;
                    addr_d  = l_addr;
                    wdata_d = l_wdata;
                    state_d = ST_SETUP;
                end
            end

            ST_SETUP: begin
                cnt_d   = CNT_LOAD;
                state_d = ST_ACCESS;
            end

            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    // Read data is captured at the end of the last ACCESS
                    // cycle so it is visible in the DONE cycle.
                    if (!we_q) begin
                        if (owner_q) begin
                            l_rdata_d = Data;
                        end else begin
                            c_rdata_d = Data;
                        end
                    end
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= 20'h0_0000;
            wdata_q   <= 16'h0000;
            cnt_q     <= 4'd0;
            c_rdata_q <= 16'h0000;
            l_rdata_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            c_rdata_q <= c_rdata_d;
            l_rdata_q <= l_rdata_d;
        end
    end

    // Strobes decode straight from the registered state, so a reset edge
    // releases them in the same cycle the state returns to IDLE. OE is never
    // low while WE is low: reads and writes use disjoint strobe sets.
    always_comb begin
        CE      = 1'b1;
        UB      = 1'b1;
        LB      = 1'b1;
        OE      = 1'b1;
        WE      = 1'b1;
        data_oe = 1'b0;

        case (state_q)
            ST_SETUP: begin
                CE = 1'b0;
                UB = 1'b0;
                LB = 1'b0;
                OE = we_q;
            end

            ST_ACCESS: begin
                CE      = 1'b0;
                UB      = 1'b0;
                LB      = 1'b0;
                OE      = we_q;
                WE      = ~we_q;
                data_oe = we_q;
            end

            default: begin
                CE = 1'b1;
            end
        endcase
    end

    assign Data    = data_oe ? wdata_q : 16'hzzzz;
    assign ADDR    = addr_q;

    assign c_rdata = c_rdata_q;
    assign l_rdata = l_rdata_q;
    assign c_done  = (state_q == ST_DONE) && !owner_q;
    assign l_done  = (state_q == ST_DONE) &&  owner_q;

    assign busy    = (state_q != ST_IDLE);
    assign owner   = owner_q;

endmodule
